// File: rtl/lut4.sv
// Configurable 4-input look-up table: 16-bit truth table loaded in parallel or
// shifted in serially (MSB first), with combinational (F) and registered (X) outputs.
module lut4 #(
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic        cfg_we,
    input  logic [15:0] cfg_data,
    input  logic        cfg_sen,
    input  logic        cfg_sin,
    output logic        cfg_sout,
    output logic        F,
    output logic        X
);

    logic [15:0] table_reg;
    logic [15:0] table_next;
    logic [15:0] shift_next;
    logic        x_reg;
    logic [3:0]  idx;

    assign idx = {A, B, C, D};

    // Serial path: each bit moves one place up, new bit enters at bit 0.
    assign shift_next[0] = cfg_sin;
    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_shift
            assign shift_next[gi] = table_reg[gi-1];
        end
    endgenerate

    always_comb begin
        table_next = table_reg;
        if (cfg_we) begin
            table_next = cfg_data;
        end else if (cfg_sen) begin
            table_next = shift_next;
        end
    end

    // X captures F from before the edge, so it lags any same-edge table update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_reg <= INIT;
            x_reg     <= 1'b0;
        end else begin
            table_reg <= table_next;
            x_reg     <= F;
        end
    end

    assign F        = table_reg[idx];
    assign X        = x_reg;
    assign cfg_sout = table_reg[15];

endmodule

// File: tb/tb_lut4.sv
// Self-checking bench for lut4: one standalone cell plus a two-cell serial chain,
// compared against truth-table models held as plain integers.
module tb_lut4;

    logic        clk;
    logic [3:0]  idx;

    logic        rst_n, we, sen, sin;
    logic [15:0] data;
    logic        sout, f, x;

    logic        rst2_n, we2, sen2, sin2;
    logic [15:0] data2;
    logic        sout0, sout1, f0, f1, x0, x1;

    int checks = 0;
    int errors = 0;
    int ntx    = 0;

    lut4 #(.INIT(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .A(idx[3]), .B(idx[2]), .C(idx[1]), .D(idx[0]),
        .cfg_we(we), .cfg_data(data), .cfg_sen(sen), .cfg_sin(sin),
        .cfg_sout(sout), .F(f), .X(x)
    );

    lut4 #(.INIT(16'h0000)) cell0 (
        .clk(clk), .rst_n(rst2_n), .A(idx[3]), .B(idx[2]), .C(idx[1]), .D(idx[0]),
        .cfg_we(we2), .cfg_data(data2), .cfg_sen(sen2), .cfg_sin(sin2),
        .cfg_sout(sout0), .F(f0), .X(x0)
    );

    lut4 #(.INIT(16'hAAAA)) cell1 (
        .clk(clk), .rst_n(rst2_n), .A(idx[3]), .B(idx[2]), .C(idx[1]), .D(idx[0]),
        .cfg_we(we2), .cfg_data(data2), .cfg_sen(sen2), .cfg_sin(sout0),
        .cfg_sout(sout1), .F(f1), .X(x1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic tt_bit(input logic [15:0] t, input logic [3:0] i);
        return ((t >> i) & 16'h0001) != 16'h0000;
    endfunction

    // Reference: standalone table as an integer, and the chain as one 32-bit shifter.
    logic [15:0] m_tbl;
    logic        m_x;
    logic [31:0] m_ch;
    logic        m_x0, m_x1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tbl <= 16'h0000;
            m_x   <= 1'b0;
        end else begin
            m_x <= tt_bit(m_tbl, idx);
            if (we)       m_tbl <= data;
            else if (sen) m_tbl <= (m_tbl << 1) | {15'b0, sin};
        end
    end

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) begin
            m_ch <= {16'hAAAA, 16'h0000};
            m_x0 <= 1'b0;
            m_x1 <= 1'b0;
        end else begin
            m_x0 <= tt_bit(m_ch[15:0], idx);
            m_x1 <= tt_bit(m_ch[31:16], idx);
            if (we2)       m_ch <= {data2, data2};
            else if (sen2) m_ch <= (m_ch << 1) | {31'b0, sin2};
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".F"},     f,     tt_bit(m_tbl, idx));
        chk({tag, ".X"},     x,     m_x);
        chk({tag, ".sout"},  sout,  m_tbl[15]);
        chk({tag, ".F0"},    f0,    tt_bit(m_ch[15:0], idx));
        chk({tag, ".X0"},    x0,    m_x0);
        chk({tag, ".sout0"}, sout0, m_ch[15]);
        chk({tag, ".F1"},    f1,    tt_bit(m_ch[31:16], idx));
        chk({tag, ".X1"},    x1,    m_x1);
        chk({tag, ".sout1"}, sout1, m_ch[31]);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
        ntx++;
        $display("txn %0d %s idx=%0d F=%b X=%b sout=%b F0=%b F1=%b", ntx, tag, idx, f, x, sout, f0, f1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] word;
        logic [15:0] exp0, exp1;

        idx = 4'd0; we = 1'b0; data = 16'h0; sen = 1'b0; sin = 1'b0;
        we2 = 1'b0; data2 = 16'h0; sen2 = 1'b0; sin2 = 1'b0;
        rst_n = 1'b1; rst2_n = 1'b1;

        // Reset state, before any clock edge.
        #3 rst_n = 1'b0; rst2_n = 1'b0;
        #1;
        chk("rst.X", x, 1'b0);
        chk("rst.F", f, 1'b0);
        chk("rst.sout", sout, 1'b0);
        chk("rst.sout1", sout1, 1'b1);
        chk("rst.F1_idx0", f1, 1'b0);
        idx = 4'd1;
        #1;
        chk("rst.F1_idx1", f1, 1'b1);
        check_all("rst");
        rst_n = 1'b1; rst2_n = 1'b1;

        // Parallel XOR4 load and exhaustive sweep.
        we = 1'b1; data = 16'h6996;
        tick("xor_load");
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            #1 chk("xor.F", f, ^idx);
            tick("xor");
        end

        // Serial AND4 load after reset.
        rst_n = 1'b0;
        #1 check_all("ser_rst");
        rst_n = 1'b1;
        sen = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sin = (i == 0);
            idx = 4'($urandom_range(0, 15));
            tick("ser");
        end
        sen = 1'b0; sin = 1'b0;
        chk("ser.sout16", sout, 1'b1);
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            #1 chk("and4.F", f, i == 15);
            tick("and4");
        end

        // Parallel load wins over a concurrent shift.
        we = 1'b1; data = 16'hFFFE; sen = 1'b1; sin = 1'b0;
        tick("prio_load");
        we = 1'b0; sen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            #1 chk("or4.F", f, i != 0);
            tick("or4");
        end

        // Registered latency: F moves at once, X one edge later.
        we = 1'b1; data = 16'h8000; idx = 4'd0;
        tick("lat_load");
        we = 1'b0;
        tick("lat_idle");
        idx = 4'd15;
        #1;
        chk("lat.F", f, 1'b1);
        chk("lat.X_hold", x, 1'b0);
        tick("lat");
        chk("lat.X", x, 1'b1);

        // Chaining: 32 bits through cell0 into cell1.
        rst2_n = 1'b0;
        #1 rst2_n = 1'b1;
        word = {16'h1234, 16'hABCD};
        sen2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            sin2 = word[31-i];
            tick("chain");
        end
        sen2 = 1'b0; sin2 = 1'b0;
        exp0 = 16'hABCD;
        exp1 = 16'h1234;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            #1;
            chk("chain.F0", f0, exp0[i]);
            chk("chain.F1", f1, exp1[i]);
            tick("chain_chk");
        end

        // Asynchronous reset mid-cycle restores INIT and clears X.
        we2 = 1'b1; data2 = 16'hFFFF; idx = 4'd1;
        tick("arst_ones");
        data2 = 16'h0000;
        tick("arst_zero");
        we2 = 1'b0;
        chk("arst.X1_pre", x1, 1'b1);
        #3 rst2_n = 1'b0;
        #1;
        chk("arst.X1", x1, 1'b0);
        chk("arst.F1", f1, 1'b1);
        chk("arst.sout1", sout1, 1'b1);
        check_all("arst");
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            #1 chk("arst.F1_eq_D", f1, idx[0]);
            tick("arst_hold");
        end
        rst2_n = 1'b1;

        // Randomised traffic against the models.
        for (int n = 0; n < 200; n++) begin
            idx   = 4'($urandom_range(0, 15));
            we    = ($urandom_range(0, 7) == 0);
            data  = 16'($urandom);
            sen   = ($urandom_range(0, 2) == 0);
            sin   = 1'($urandom_range(0, 1));
            we2   = ($urandom_range(0, 9) == 0);
            data2 = 16'($urandom);
            sen2  = ($urandom_range(0, 1) == 0);
            sin2  = 1'($urandom_range(0, 1));
            tick("rand");
        end
        we = 1'b0; sen = 1'b0; we2 = 1'b0; sen2 = 1'b0;
        tick("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut4.md
# lut4

Configurable 4-input look-up table with a 16-bit truth-table memory, serial and parallel configuration paths, a combinational output and a registered output. It is the basic logic cell of the course's combinational exercises. It sits between the stimulus/input fabric (A, B, C, D) and downstream logic. It can be daisy-chained with other cells through its serial configuration port.

## Interface
- INIT, 16'h0000: truth table loaded on reset. Bit i is the output for {A,B,C,D} = i.
- clk  input  1  rising-edge clock for configuration storage and registered output
- rst_n  input  1  asynchronous, active-low reset
- A  input  1  select bit 3 (MSB of the index)
- B  input  1  select bit 2
- C  input  1  select bit 1
- D  input  1  select bit 0 (LSB)
- cfg_we  input  1  parallel load strobe
- cfg_data  input  16  parallel truth table
- cfg_sen  input  1  serial shift enable
- cfg_sin  input  1  serial configuration data in
- cfg_sout  output  1  serial configuration data out; equals table[15]
- F  output  1  combinational result: table[{A,B,C,D}]
- X  output  1  registered result: F sampled on each rising edge of clk

## Operation
- Storage:
  - Single 16-bit register `table`.
  - Index idx = {A,B,C,D}, range 0..15, A is MSB.
- Reset:
  - While rst_n = 0: table = INIT and X = 0, independent of clk.
  - F follows INIT combinationally during reset.
  - cfg_sout = INIT[15] during reset.
- Configuration, evaluated on each rising clk edge, in priority order:
  1. cfg_we = 1: table <= cfg_data. Any concurrent cfg_sen is ignored.
  2. Otherwise, if cfg_sen = 1: table <= {table[14:0], cfg_sin}.
     - Shifting is MSB first: after 16 shifts, the first bit shifted in is at bit 15.
     - cfg_sout presents the bit being shifted out, so cells chain sout -> sin.
  3. Otherwise: table holds its value.
- Evaluation:
  - F = table[idx]. Purely combinational, with no dependence on clk.
  - X <= F on every rising clk edge, regardless of the configuration strobes.
  - X samples the F value from before the edge, i.e. the table contents prior to any same-edge update.
- Inputs A–D that are X/Z propagate as unknown on F. No sanitising is done.

## Timing
- F:
  - Zero-cycle latency from A–D.
  - One cycle from a configuration edge: the new table is visible on F immediately after the edge.
- X:
  - One-cycle latency from A–D.
  - Two edges from a configuration write to X reflecting the new table.
- cfg_sout changes only on clock edges or reset.
- Reset mid-shift:
  - Aborts the shift sequence; the table reverts to INIT.
  - The next shift sequence must supply all 16 bits again.
- Reset deassertion needs no synchronisation inside the block. The integrating level provides a synchronised rst_n release.
- Simultaneous events:
  - cfg_we dominates cfg_sen.
  - Reset dominates everything.

## Test plan
- Exhaustive sweep with INIT = 16'h0000:
  - Parallel-load cfg_data = 16'h6996 (4-input XOR).
  - Apply {A,B,C,D} = 0..15, 20 ns per step.
  - Required: F = ^{A,B,C,D}, e.g. idx 0 -> 0, idx 1 -> 1, idx 3 -> 0, idx 15 -> 0. X equals the previous cycle's F.
- Serial load:
  - Reset, then shift 16'h8000 MSB first over 16 cycles with cfg_sen = 1.
  - Required: F = 1 only at idx 15 (AND4).
  - Required: cfg_sout goes 1 at the 16th edge, having shifted out the INIT bits during the sequence.
- Priority:
  - In one cycle, assert cfg_we = 1 with cfg_data = 16'hFFFE and cfg_sen = 1 with cfg_sin = 0.
  - Required: table = 16'hFFFE (OR4). idx 0 -> 0; any other idx -> 1.
- Async reset mid-operation:
  - INIT = 16'hAAAA; load 16'h0000; pulse rst_n low between clock edges.
  - Required: X = 0 and table = 16'hAAAA immediately, before the next edge.
  - Required: F = D (1 at every odd idx).
- Chaining:
  - Two cells with sout -> sin; shift 32 bits, 16'h1234 followed by 16'hABCD.
  - Required: the first cell holds 16'hABCD and the second holds 16'h1234.
- Registered latency:
  - Toggle idx 0 -> 15 with table = 16'h8000.
  - Required: F rises in the same cycle; X rises at the next clk edge.
